// File: rtl/ternary_systolic_stream_pkg.sv
// Shared types and arithmetic helpers for the ternary systolic stream.
// Ternary weight encoding, FSM state enum, and the PE add/saturate functions.
package ternary_pkg;

  typedef logic [1:0] tern_t;

  localparam tern_t TERN_ZERO = 2'b00;
  localparam tern_t TERN_POS  = 2'b01;
  localparam tern_t TERN_RSVD = 2'b10;
  localparam tern_t TERN_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Callers pass x already widened to 64 signed bits; the reserved code acts as zero.
  function automatic logic signed [63:0] tern_apply(input tern_t w, input logic signed [63:0] x);
    case (w)
      TERN_POS: return x;
      TERN_NEG: return -x;
      default:  return 64'sd0;
    endcase
  endfunction

  // Widths up to 63 bits are supported; wrap is left to the caller's truncation.
  function automatic logic signed [63:0] acc_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w,
                                                 input logic sat);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sat && (sum > hi)) return hi;
    if (sat && (sum < lo)) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/ternary_systolic_stream_pe.sv
// One processing element: forwards weight right and activation down, and
// accumulates +x / -x / 0 whenever both incoming operands are valid.
module ternary_pe
  import ternary_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        clear_i,
  input  logic                        sat_en_i,
  input  tern_t                       w_i,
  input  logic                        wv_i,
  input  logic signed [WIDTH-1:0]     x_i,
  input  logic                        xv_i,
  output tern_t                       w_o,
  output logic                        wv_o,
  output logic signed [WIDTH-1:0]     x_o,
  output logic                        xv_o,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  tern_t                       w_q;
  logic                        wv_q;
  logic signed [WIDTH-1:0]     x_q;
  logic                        xv_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (wv_i && xv_i)
      acc_d = ACC_WIDTH'(acc_add(64'(acc_q), tern_apply(w_i, 64'(x_i)), ACC_WIDTH, sat_en_i));
  end

  always_ff @(posedge clock) begin
    if (clear_i) begin
      w_q   <= TERN_ZERO;
      wv_q  <= 1'b0;
      x_q   <= '0;
      xv_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      w_q   <= w_i;
      wv_q  <= wv_i;
      x_q   <= x_i;
      xv_q  <= xv_i;
      acc_q <= acc_d;
    end
  end

  assign w_o   = w_q;
  assign wv_o  = wv_q;
  assign x_o   = x_q;
  assign xv_o  = xv_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/ternary_systolic_stream.sv
// Output-stationary ternary systolic array with handshaked input stream,
// internal operand skewing, runtime K and row-serial result drain.
module ternary_systolic_stream
  import ternary_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 2 * WIDTH
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  k_len,
  input  logic                         sat_en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*2-1:0]            w_in,
  input  logic [COLS*WIDTH-1:0]        x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(ROWS)-1:0]      out_row,
  output logic [COLS*ACC_WIDTH-1:0]    y_out,
  output logic                         busy,
  output logic                         done
);

  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS + COLS);

  state_t        state_q, state_d;
  logic [15:0]   k_q, k_d;
  logic [15:0]   beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          sat_q, sat_d;
  logic          done_q, done_d;
  logic          launch;
  logic          accept;
  logic          clear;

  assign launch = (state_q == IDLE) && start;
  assign accept = (state_q == FEED) && in_valid;
  assign clear  = !rst || launch;

  // Flush length equals the skew depth to the far corner PE, so DRAIN opens
  // on the same edge that PE(ROWS-1,COLS-1) takes its final update.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k_len;
          sat_d   = sat_en;
          beat_d  = '0;
          flush_d = '0;
          row_d   = '0;
          state_d = (k_len == 16'd0) ? DRAIN : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          beat_d = beat_q + 16'd1;
          if (beat_q == k_q - 16'd1) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(ROWS + COLS - 2)) begin
          state_d = DRAIN;
          row_d   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  wire [1:0]       wh  [ROWS][COLS+1];
  wire             whv [ROWS][COLS+1];
  wire [WIDTH-1:0] xd  [ROWS+1][COLS];
  wire             xdv [ROWS+1][COLS];
  wire [ACC_WIDTH-1:0] acc [ROWS][COLS];

  // Stage 0 captures the accepted beat; row r then delays r more cycles.
  for (genvar r = 0; r < ROWS; r++) begin : g_wskew
    tern_t sk_q  [r+1];
    logic  skv_q [r+1];
    always_ff @(posedge clock) begin
      if (clear) begin
        for (int s = 0; s <= r; s++) begin
          sk_q[s]  <= TERN_ZERO;
          skv_q[s] <= 1'b0;
        end
      end else begin
        sk_q[0]  <= accept ? w_in[2*r +: 2] : TERN_ZERO;
        skv_q[0] <= accept;
        for (int s = 1; s <= r; s++) begin
          sk_q[s]  <= sk_q[s-1];
          skv_q[s] <= skv_q[s-1];
        end
      end
    end
    assign wh[r][0]  = sk_q[r];
    assign whv[r][0] = skv_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_xskew
    logic [WIDTH-1:0] sk_q  [c+1];
    logic             skv_q [c+1];
    always_ff @(posedge clock) begin
      if (clear) begin
        for (int s = 0; s <= c; s++) begin
          sk_q[s]  <= '0;
          skv_q[s] <= 1'b0;
        end
      end else begin
        sk_q[0]  <= accept ? x_in[c*WIDTH +: WIDTH] : '0;
        skv_q[0] <= accept;
        for (int s = 1; s <= c; s++) begin
          sk_q[s]  <= sk_q[s-1];
          skv_q[s] <= skv_q[s-1];
        end
      end
    end
    assign xd[0][c]  = sk_q[c];
    assign xdv[0][c] = skv_q[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      ternary_pe #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clock    (clock),
        .clear_i  (clear),
        .sat_en_i (sat_q),
        .w_i      (wh[r][c]),
        .wv_i     (whv[r][c]),
        .x_i      (xd[r][c]),
        .xv_i     (xdv[r][c]),
        .w_o      (wh[r][c+1]),
        .wv_o     (whv[r][c+1]),
        .x_o      (xd[r+1][c]),
        .xv_o     (xdv[r+1][c]),
        .acc_o    (acc[r][c])
      );
    end
  end

  always_comb begin
    y_out = '0;
    for (int c = 0; c < COLS; c++)
      y_out[c*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][c];
  end

  assign in_ready  = (state_q == FEED);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_row   = row_q;

endmodule
